// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: 32 cycles per operation on
// operand magnitudes, sign fix-up on the last iteration, divide-by-zero fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic [1:0]      state_r;
  logic [4:0]      cnt_r;
  logic [2:0]      op_r;
  logic            neg_r;
  logic            rem_neg_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opnd_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  logic            signed_a_s;
  logic            signed_b_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic            div_zero_s;
  logic [XLEN-1:0] fast_res_s;

  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   div_shift_s;
  logic [XLEN+1:0] div_diff_s;
  logic            qbit_s;
  logic [XLEN-1:0] hi_nxt_s;
  logic [XLEN-1:0] lo_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quot_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] final_res_s;

  // Operand classification and magnitude conversion at request capture.
  always_comb begin
    signed_a_s = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    signed_b_s = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg_s    = signed_a_s & srcA_i[XLEN-1];
    b_neg_s    = signed_b_s & srcB_i[XLEN-1];
    if (a_neg_s) begin
      mag_a_s = ~srcA_i + 32'd1;
    end else begin
      mag_a_s = srcA_i;
    end
    if (b_neg_s) begin
      mag_b_s = ~srcB_i + 32'd1;
    end else begin
      mag_b_s = srcB_i;
    end
    div_zero_s = op_i[2] & (srcB_i == 32'd0);
    // REM/REMU have funct3 bit 1 set; they return the dividend on /0.
    if (op_i[1]) begin
      fast_res_s = srcA_i;
    end else begin
      fast_res_s = {XLEN{1'b1}};
    end
  end

  // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : 33'd0);
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
    qbit_s      = ~div_diff_s[XLEN+1];
    if (op_r[2]) begin
      lo_nxt_s = {lo_r[XLEN-2:0], qbit_s};
      if (qbit_s) begin
        hi_nxt_s = div_diff_s[XLEN-1:0];
      end else begin
        hi_nxt_s = div_shift_s[XLEN-1:0];
      end
    end else begin
      hi_nxt_s = mul_sum_s[XLEN:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection applied on the final iteration.
  always_comb begin
    prod_s = {hi_nxt_s, lo_nxt_s};
    if (neg_r) begin
      prod_s = ~prod_s + 64'd1;
      quot_s = ~lo_nxt_s + 32'd1;
    end else begin
      quot_s = lo_nxt_s;
    end
    if (rem_neg_r) begin
      rem_s = ~hi_nxt_s + 32'd1;
    end else begin
      rem_s = hi_nxt_s;
    end
    case (op_r)
      OP_MUL:    final_res_s = prod_s[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  final_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   final_res_s = quot_s;
      OP_REM,
      OP_REMU:   final_res_s = rem_s;
      default:   final_res_s = 32'd0;
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 5'd0;
      op_r      <= 3'd0;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      opnd_r    <= 32'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            op_r      <= op_i;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            cnt_r     <= 5'd0;
            hi_r      <= 32'd0;
            if (div_zero_s) begin
              state_r  <= ST_DONE;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
            end else begin
              state_r <= ST_CALC;
              busy_r  <= 1'b1;
              // Multiply keeps the multiplier in lo; divide shifts the dividend out of lo.
              if (op_i[2]) begin
                lo_r   <= mag_a_s;
                opnd_r <= mag_b_s;
              end else begin
                lo_r   <= mag_b_s;
                opnd_r <= mag_a_s;
              end
            end
          end
        end
        ST_CALC: begin
          hi_r  <= hi_nxt_s;
          lo_r  <= lo_nxt_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= final_res_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] srcA_i;
  logic [31:0] srcB_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks;
  int errors;
  int done_cnt;
  logic [31:0] exp_q[$];
  string       name_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .srcA_i  (srcA_i),
    .srcB_i  (srcB_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result 0x%08h expected no done", result_o);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (result_o !== e) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, result_o, e);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit fast, input string nm);
    int k;
    int nbusy;
    @(negedge clk_i);
    op_i = op; srcA_i = a; srcB_i = b; start_i = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    k = 0;
    nbusy = busy_o ? 1 : 0;
    while (done_o !== 1'b1 && k < 40) begin
      @(posedge clk_i); #1;
      k++;
      if (busy_o === 1'b1) nbusy++;
    end
    check({nm, "_latency"}, k, fast ? 32'd0 : 32'd32);
    check({nm, "_busy_cycles"}, nbusy, fast ? 32'd0 : 32'd32);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int w;
    checks = 0; errors = 0; done_cnt = 0;
    rst_i = 1'b0; start_i = 1'b0; op_i = 3'd0; srcA_i = 32'd0; srcB_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh_m1_m1");
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu_m1_max");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max_max");
    run_op(3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 1'b0, "mulhu_2p31_2");
    run_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_m7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem_m7_2");
    run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "divu_big");
    run_op(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "remu_big");
    run_op(3'b101, 32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7");
    run_op(3'b111, 32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7");
    run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "div_5_0");
    run_op(3'b110, 32'd5,        32'd0,        32'd5,        1'b1, "rem_5_0");
    run_op(3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_9_0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_overflow");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "rem_overflow");

    // start held for 40 cycles; operands churn during the first computation.
    base = done_cnt;
    @(negedge clk_i);
    op_i = 3'b000; srcA_i = 32'd3; srcB_i = 32'd5; start_i = 1'b1;
    exp_q.push_back(32'd15);  name_q.push_back("held_first");
    exp_q.push_back(32'd143); name_q.push_back("held_second");
    for (int i = 1; i < 40; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (i <= 20) begin
        srcA_i = i * 1000;
        srcB_i = i;
      end else if (i == 21) begin
        srcA_i = 32'd11;
        srcB_i = 32'd13;
      end
    end
    start_i = 1'b0;
    w = 0;
    while (done_cnt - base < 2 && w < 80) begin
      @(posedge clk_i);
      w++;
    end
    repeat (4) @(posedge clk_i);
    check("held_start_done_count", done_cnt - base, 32'd2);

    // Reset during CALC: abort with no done, then a clean operation.
    @(negedge clk_i);
    op_i = 3'b000; srcA_i = 32'd7; srcB_i = 32'd9; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    base = done_cnt;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (30) @(posedge clk_i);
    check("abort_no_done", done_cnt - base, 32'd0);
    run_op(3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 1'b0, "after_reset_mulhu");

    repeat (3) @(posedge clk_i);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
